regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between ALU and load results, with a registered register-file write port,
// a PC redirect for r15 and a pending-write scoreboard. Optional macro: WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ALU_V,
  output logic        ALU_RDY,
  input  logic [3:0]  ALU_A,
  input  logic [31:0] ALU_D,
  input  logic        LD_V,
  output logic        LD_RDY,
  input  logic [3:0]  LD_A,
  input  logic [31:0] LD_D,
  input  logic        ISSUE_V,
  input  logic [3:0]  ISSUE_RD,
  input  logic [3:0]  CHK_A1,
  input  logic [3:0]  CHK_A2,
  input  logic [3:0]  CHK_RD,
  output logic        BUSY_HIT,
  output logic        WE3,
  output logic [3:0]  A3,
  output logic [31:0] WD3,
  output logic        PC_LD,
  output logic [31:0] PC_VAL,
  output logic [15:0] SCB
);

  localparam int unsigned CW = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
  localparam logic [3:0] PC_REG = 4'd15;

  logic [CW-1:0] starve;
  logic          alu_win;
  logic          alu_acc;
  logic          ld_acc;
  logic          wb_acc;
  logic [3:0]    wb_a;
  logic [31:0]   wb_d;
  logic          we3_q;
  logic          pc_ld_q;
  logic [15:0]   scb_q;
  logic [15:0]   scb_set;
  logic [15:0]   scb_clr;
  logic [15:0]   busy_vec;

  // LD has priority unless the ALU has lost STARVE_MAX arbitrations in a row.
  always_comb begin
    alu_win = ALU_V && (!LD_V || (starve == STARVE_LIM));
    ALU_RDY = !RST && alu_win;
    LD_RDY  = !RST && LD_V && !alu_win;
    alu_acc = ALU_V && ALU_RDY;
    ld_acc  = LD_V && LD_RDY;
    wb_acc  = alu_acc || ld_acc;
    wb_a    = alu_acc ? ALU_A : LD_A;
    wb_d    = alu_acc ? ALU_D : LD_D;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve <= '0;
    end else if (!ALU_V || alu_acc) begin
      starve <= '0;
    end else if (ld_acc && (starve != STARVE_LIM)) begin
      starve <= starve + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      we3_q   <= 1'b0;
      pc_ld_q <= 1'b0;
      A3      <= '0;
      WD3     <= '0;
      PC_VAL  <= '0;
    end else begin
      we3_q   <= wb_acc && (wb_a != PC_REG);
      pc_ld_q <= wb_acc && (wb_a == PC_REG);
      if (wb_acc && (wb_a != PC_REG)) begin
        A3  <= wb_a;
        WD3 <= wb_d;
      end
      if (wb_acc && (wb_a == PC_REG)) begin
        PC_VAL <= wb_d;
      end
    end
  end

  // A write still in the output stage when reset arrives is discarded, not emitted.
  assign WE3   = we3_q && !RST;
  assign PC_LD = pc_ld_q && !RST;

  always_comb begin
    scb_set = '0;
    scb_clr = '0;
    if (ISSUE_V && (ISSUE_RD != PC_REG)) begin
      scb_set[ISSUE_RD] = 1'b1;
    end
    if (WE3) begin
      scb_clr[A3] = 1'b1;
    end
  end

  // Set is ORed in after the clear so a same-edge issue keeps the bit pending.
  always_ff @(posedge CLK) begin
    if (RST) begin
      scb_q <= '0;
    end else begin
      scb_q <= ((scb_q & ~scb_clr) | scb_set) & 16'h7FFF;
    end
  end

  assign SCB = scb_q;

  always_comb begin
    busy_vec = scb_q;
`ifdef WB_BYPASS_EN
    if (WE3 && !(ISSUE_V && (ISSUE_RD == A3))) begin
      busy_vec[A3] = 1'b0;
    end
`endif
    BUSY_HIT = busy_vec[CHK_A1] | busy_vec[CHK_A2] | busy_vec[CHK_RD];
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// checked against a behavioural model of grants, scoreboard bits and writebacks.
module tb_regfile_wb_arbiter;

  localparam int SMAX = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ALU_V, LD_V, ISSUE_V;
  logic        ALU_RDY, LD_RDY, BUSY_HIT, WE3, PC_LD;
  logic [3:0]  ALU_A, LD_A, ISSUE_RD, CHK_A1, CHK_A2, CHK_RD, A3;
  logic [31:0] ALU_D, LD_D, WD3, PC_VAL;
  logic [15:0] SCB;

  regfile_wb_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_V(ALU_V), .ALU_RDY(ALU_RDY), .ALU_A(ALU_A), .ALU_D(ALU_D),
    .LD_V(LD_V), .LD_RDY(LD_RDY), .LD_A(LD_A), .LD_D(LD_D),
    .ISSUE_V(ISSUE_V), .ISSUE_RD(ISSUE_RD),
    .CHK_A1(CHK_A1), .CHK_A2(CHK_A2), .CHK_RD(CHK_RD),
    .BUSY_HIT(BUSY_HIT), .WE3(WE3), .A3(A3), .WD3(WD3),
    .PC_LD(PC_LD), .PC_VAL(PC_VAL), .SCB(SCB)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    bit          pc;
    logic [3:0]  a;
    logic [31:0] d;
  } wb_t;

  wb_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: evaluated mid-cycle once inputs are stable.
  int          starve_m = 0;
  bit [15:0]   pend = '0;
  bit          cur_we = 0;
  logic [3:0]  cur_a = '0;

  initial begin
    bit          g_alu, g_ld, busy;
    bit [15:0]   vis;
    logic [3:0]  a;
    logic [31:0] d;
    forever begin
      @(posedge CLK);
      #3;
      g_alu = 0;
      g_ld  = 0;
      if (!RST) begin
        if (ALU_V && LD_V) begin
          if (starve_m == SMAX) g_alu = 1;
          else g_ld = 1;
        end else if (ALU_V) begin
          g_alu = 1;
        end else if (LD_V) begin
          g_ld = 1;
        end
      end
      check("alu_rdy", 32'(ALU_RDY), 32'(g_alu));
      check("ld_rdy", 32'(LD_RDY), 32'(g_ld));
      check("scb", 32'(SCB), 32'(pend));
      vis = pend;
`ifdef WB_BYPASS_EN
      if (cur_we && !RST && !(ISSUE_V && ISSUE_RD == cur_a)) vis[cur_a] = 0;
`endif
      busy = vis[CHK_A1] | vis[CHK_A2] | vis[CHK_RD];
      check("busy_hit", 32'(BUSY_HIT), 32'(busy));

      if (RST) begin
        starve_m = 0;
        pend     = '0;
        cur_we   = 0;
      end else begin
        if (g_alu || !ALU_V) starve_m = 0;
        else if (starve_m < SMAX) starve_m++;
        if (cur_we) pend[cur_a] = 0;
        if (ISSUE_V && ISSUE_RD != 4'd15) pend[ISSUE_RD] = 1;
        cur_we = 0;
        if (g_alu || g_ld) begin
          a = g_alu ? ALU_A : LD_A;
          d = g_alu ? ALU_D : LD_D;
          q.push_back('{cyc + 1, (a == 4'd15), a, d});
          cur_we = (a != 4'd15);
          cur_a  = a;
        end
      end
    end
  end

  // Monitor: compares the write port against queued expectations every cycle.
  initial begin
    wb_t e;
    bit  prev_rst = 0;
    forever begin
      @(negedge CLK);
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        check("stale_writeback", 32'(e.due), 32'(cyc));
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (RST) begin
          check("rst_we3", 32'(WE3), 32'd0);
          check("rst_pc_ld", 32'(PC_LD), 32'd0);
        end else if (e.pc) begin
          check("pc_ld", 32'(PC_LD), 32'd1);
          check("pc_val", PC_VAL, e.d);
          check("pc_we3", 32'(WE3), 32'd0);
        end else begin
          check("we3", 32'(WE3), 32'd1);
          check("a3", 32'(A3), 32'(e.a));
          check("wd3", WD3, e.d);
          check("wb_pc_ld", 32'(PC_LD), 32'd0);
        end
      end else begin
        check("idle_we3", 32'(WE3), 32'd0);
        check("idle_pc_ld", 32'(PC_LD), 32'd0);
        if (prev_rst) begin
          check("rst_a3", 32'(A3), 32'd0);
          check("rst_wd3", WD3, 32'd0);
          check("rst_pc_val", PC_VAL, 32'd0);
        end
      end
      prev_rst = RST;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit alu_acc, ld_acc;
    RST = 1; ALU_V = 0; LD_V = 0; ISSUE_V = 0;
    ALU_A = '0; ALU_D = '0; LD_A = '0; LD_D = '0;
    ISSUE_RD = '0; CHK_A1 = '0; CHK_A2 = '0; CHK_RD = '0;
    step(); step();
    RST = 0;
    step();

    // Single ALU writeback.
    ALU_V = 1; ALU_A = 4'd4; ALU_D = 32'h11;
    step();
    ALU_V = 0;
    step(); step();

    // Both requesters held valid: LD,LD,LD,ALU pattern.
    ALU_V = 1; ALU_A = 4'd5; ALU_D = 32'hA5A5;
    LD_V = 1; LD_A = 4'd6; LD_D = 32'h5A5A;
    repeat (12) step();
    ALU_V = 0; LD_V = 0;
    step();

    // Load to r15 redirects the PC.
    LD_V = 1; LD_A = 4'd15; LD_D = 32'h100;
    step();
    LD_V = 0;
    step(); step();

    // Hazard on r7, then re-issue on the clearing edge.
    ISSUE_V = 1; ISSUE_RD = 4'd7; CHK_A1 = 4'd7;
    step();
    ISSUE_V = 0;
    repeat (3) step();
    ALU_V = 1; ALU_A = 4'd7; ALU_D = 32'h77;
    step();
    ALU_V = 0; ISSUE_V = 1; ISSUE_RD = 4'd7;
    step();
    ISSUE_V = 0;
    step();
    ALU_V = 1; ALU_A = 4'd7; ALU_D = 32'h78;
    step();
    ALU_V = 0;
    step(); step();

    // Reset right after an accepted write discards it.
    ISSUE_V = 1; ISSUE_RD = 4'd3;
    step();
    ISSUE_V = 0;
    ALU_V = 1; ALU_A = 4'd3; ALU_D = 32'h33;
    step();
    ALU_V = 0; RST = 1;
    step();
    RST = 0;
    step(); step();

    // Random traffic honouring the hold-until-accepted rule.
    for (int i = 0; i < 600; i++) begin
      alu_acc = ALU_V && ALU_RDY;
      ld_acc  = LD_V && LD_RDY;
      @(posedge CLK);
      #1;
      if (!ALU_V || alu_acc) begin
        ALU_V = ($urandom_range(0, 9) < 6);
        ALU_A = 4'($urandom_range(0, 15));
        ALU_D = $urandom;
      end
      if (!LD_V || ld_acc) begin
        LD_V = ($urandom_range(0, 9) < 6);
        LD_A = 4'($urandom_range(0, 15));
        LD_D = $urandom;
      end
      ISSUE_V  = ($urandom_range(0, 9) < 4);
      ISSUE_RD = 4'($urandom_range(0, 15));
      CHK_A1   = 4'($urandom_range(0, 15));
      CHK_A2   = 4'($urandom_range(0, 15));
      CHK_RD   = 4'($urandom_range(0, 15));
      RST      = ($urandom_range(0, 63) == 0);
    end

    RST = 0; ALU_V = 0; LD_V = 0; ISSUE_V = 0;
    repeat (4) step();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
